// File: rtl/led_blink_pio_if.sv
// -----------------------------------------------------------------------------
// led_blink_pio_if
//
// Avalon-MM slave bus bundle used by the LED output PIO. The Nios II
// interconnect (or a testbench) drives it through the master modport. The PIO
// itself connects through the slave modport.
//
// Signals:
//   address     3   register select
//   chipselect  1   slave select
//   write_n     1   active-low write strobe
//   writedata   32  write data
//   readdata    32  registered read data, zero-extended, from the slave
// -----------------------------------------------------------------------------
interface led_blink_pio_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/led_blink_pio.sv
// -----------------------------------------------------------------------------
// led_blink_pio
//
// Avalon-MM output PIO that drives the board LEDs. It is the output-side
// counterpart of the button input PIO. The block holds a base DATA level with
// atomic set/clear strobes. It also has a per-bit hardware blink engine: a
// prescaler produces a slow tick, and a half-period counter flips a shared
// blink phase every PERIOD ticks. Bits selected in BLINK_MASK are gated off
// during the low phase without any CPU involvement.
//
// Register map (write = chipselect && !write_n):
//   0 DATA        RW  base output level
//   1 BLINK_MASK  RW  bits that blink
//   2 PERIOD      RW  16-bit half-period in ticks, 0 disables blinking
//   3 STATUS      RO  current out_port
//   4 OUTSET      WO  DATA |= writedata, reads 0
//   5 OUTCLEAR    WO  DATA &= ~writedata, reads 0
//   6, 7              read 0, writes ignored
//
// Parameters:
//   WIDTH     number of LED outputs (1..32)
//   PRESCALE  clk cycles per blink tick (>= 2)
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   synchronous active-low reset
//   bus       Avalon-MM slave port (led_blink_pio_if.slave)
//   out_port  registered LED drive
// -----------------------------------------------------------------------------
module led_blink_pio #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  led_blink_pio_if.slave   bus,
  output logic [WIDTH-1:0] out_port
);

  typedef enum logic [2:0] {
    REG_DATA       = 3'd0,
    REG_BLINK_MASK = 3'd1,
    REG_PERIOD     = 3'd2,
    REG_STATUS     = 3'd3,
    REG_OUTSET     = 3'd4,
    REG_OUTCLEAR   = 3'd5
  } reg_addr_e;

  localparam int                PCNT_W    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

  // Register state
  logic [WIDTH-1:0]  data_reg;
  logic [WIDTH-1:0]  mask_reg;
  logic [15:0]       period_reg;

  // Blink engine state
  logic [PCNT_W-1:0] pcnt;
  logic [15:0]       hcnt;
  logic              phase;

  // Decoded write strobes
  logic              wr_en;
  logic              wr_data;
  logic              wr_mask;
  logic              wr_period;
  logic              wr_set;
  logic              wr_clear;

  logic [WIDTH-1:0]  wr_bits;
  logic [15:0]       wr_period_val;
  logic              blink_en;
  logic              tick;
  logic [15:0]       period_last;
  logic [WIDTH-1:0]  out_next;
  logic [31:0]       rd_next;

  // PERIOD only uses the low half of writedata. Above WIDTH nothing else does.
  logic              unused_writedata_hi;

  assign unused_writedata_hi = ^bus.writedata[31:16];

  assign wr_bits       = bus.writedata[WIDTH-1:0];
  assign wr_period_val = bus.writedata[15:0];

  // Write decode. STATUS, 6 and 7 fall through to no strobe, so writes there
  // are dropped.
  always_comb begin
    wr_en     = bus.chipselect && !bus.write_n;
    wr_data   = 1'b0;
    wr_mask   = 1'b0;
    wr_period = 1'b0;
    wr_set    = 1'b0;
    wr_clear  = 1'b0;
    if (wr_en) begin
      case (bus.address)
        REG_DATA:       wr_data   = 1'b1;
        REG_BLINK_MASK: wr_mask   = 1'b1;
        REG_PERIOD:     wr_period = 1'b1;
        REG_OUTSET:     wr_set    = 1'b1;
        REG_OUTCLEAR:   wr_clear  = 1'b1;
        default:        ;
      endcase
    end
  end

  // DATA register: the direct write, OUTSET and OUTCLEAR are mutually exclusive
  // because they come from different addresses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_reg <= '0;
    end else if (wr_data) begin
      data_reg <= wr_bits;
    end else if (wr_set) begin
      data_reg <= data_reg | wr_bits;
    end else if (wr_clear) begin
      data_reg <= data_reg & ~wr_bits;
    end
  end

  // BLINK_MASK and PERIOD registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_reg   <= '0;
      period_reg <= '0;
    end else begin
      if (wr_mask) begin
        mask_reg <= wr_bits;
      end
      if (wr_period) begin
        period_reg <= wr_period_val;
      end
    end
  end

  assign blink_en    = (period_reg != 16'd0);
  assign tick        = (pcnt == PCNT_LAST);
  assign period_last = period_reg - 16'd1;

  // Prescaler. A PERIOD write restarts it, so the first toggle after the
  // write lands exactly PERIOD*PRESCALE cycles later. With blinking disabled
  // it rests at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pcnt <= '0;
    end else if (wr_period) begin
      pcnt <= '0;
    end else if (blink_en) begin
      if (tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PCNT_W'(1);
      end
    end
  end

  // Half-period counter and phase. The PERIOD write wins over a coincident
  // tick or toggle. Because it also clears hcnt, shrinking PERIOD can never
  // leave hcnt above the new PERIOD-1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hcnt  <= '0;
      phase <= 1'b1;
    end else if (wr_period) begin
      hcnt  <= '0;
      phase <= 1'b1;
    end else if (blink_en && tick) begin
      if (hcnt == period_last) begin
        hcnt  <= '0;
        phase <= ~phase;
      end else begin
        hcnt <= hcnt + 16'd1;
      end
    end
  end

  // Blinking bits go dark while phase is 0. Every other bit shows DATA.
  assign out_next = data_reg & ~(mask_reg & {WIDTH{~phase}});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_port <= '0;
    end else begin
      out_port <= out_next;
    end
  end

  // Read mux. It is loaded every cycle regardless of chipselect, which gives
  // the fixed one-cycle read latency the interconnect is set up for. STATUS
  // returns the already registered out_port.
  always_comb begin
    rd_next = '0;
    case (bus.address)
      REG_DATA:       rd_next[WIDTH-1:0] = data_reg;
      REG_BLINK_MASK: rd_next[WIDTH-1:0] = mask_reg;
      REG_PERIOD:     rd_next[15:0]      = period_reg;
      REG_STATUS:     rd_next[WIDTH-1:0] = out_port;
      default:        rd_next            = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_next;
    end
  end

endmodule

// File: doc/led_blink_pio.md
# led_blink_pio

Avalon-MM slave output PIO that drives board LEDs from the Nios II system bus. It is the output-direction counterpart of the button input PIO. It provides a data register with atomic set/clear strobes and a per-bit hardware blink engine: a prescaler and a half-period counter gate selected bits on and off without CPU involvement. It sits on the system interconnect beside the button PIO, and `out_port` goes to the LED pins.

## Interface
- `WIDTH`, 4, number of output bits (1..32)
- `PRESCALE`, 50000, clk cycles per blink tick (≥2); 1 ms at 50 MHz
- `clk`  in  1  system clock; all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset; sampled on rising edge of `clk`
- `address`  in  3  register select
- `chipselect`  in  1  slave select
- `write_n`  in  1  active-low write strobe
- `writedata`  in  32  write data; bits [WIDTH-1:0] used, except PERIOD, which uses [15:0]
- `readdata`  out  32  registered read data, zero-extended
- `out_port`  out  WIDTH  registered LED drive

## Operation
- Register map, with a write qualified by `chipselect && !write_n`:
  - 0 DATA: RW. Base output level.
  - 1 BLINK_MASK: RW. Bits set here blink.
  - 2 PERIOD: RW, 16 bits. Blink half-period in ticks. 0 disables blinking.
  - 3 STATUS: RO. Current `out_port` value. Writes are ignored.
  - 4 OUTSET: WO. DATA <= DATA | writedata. Reads return 0.
  - 5 OUTCLEAR: WO. DATA <= DATA & ~writedata. Reads return 0.
  - 6, 7: read 0; writes ignored.
- Prescaler `pcnt` counts 0..PRESCALE-1 and wraps. `tick` = (pcnt == PRESCALE-1).
- Half-period counter `hcnt`:
  - When PERIOD ≠ 0, it increments on `tick`.
  - On `tick` with hcnt == PERIOD-1: hcnt <= 0 and `phase` toggles.
- PERIOD == 0: pcnt, hcnt and phase are held. pcnt and hcnt are 0; phase = 1.
- Writing PERIOD (any value): pcnt <= 0, hcnt <= 0, phase <= 1. This write takes priority over a coincident tick or toggle.
- Output function: out_next = DATA & ~(BLINK_MASK & {WIDTH{~phase}}).
  - A blinking bit shows DATA while phase = 1 and 0 while phase = 0.
  - Non-blinking bits show DATA.
- Writes to DATA and BLINK_MASK do not disturb pcnt, hcnt or phase.
- Reads are non-destructive. `readdata` is loaded every cycle from `address`, independent of `chipselect`, matching the bus wait-state setting of 1 read latency.

## Timing
- Reset (reset_n = 0 at a rising edge) clears DATA, BLINK_MASK, PERIOD, pcnt, hcnt, `readdata` and `out_port` to 0, and sets phase to 1.
  - Reset asserted mid-blink takes effect at that edge. No partial state survives.
- Write sampled at edge k: the register updates at k, and `out_port` reflects it at edge k+1.
- Read: `address` sampled at edge k; `readdata` is valid after edge k.
  - STATUS returns the `out_port` value as registered at edge k-1.
- Blink timing after a PERIOD = P write at edge k:
  - First phase toggle at edge k + P·PRESCALE.
  - Subsequent toggles every P·PRESCALE cycles.
  - `out_port` follows one cycle after each toggle.
- PERIOD values above 16 bits are truncated to [15:0].
- Counter wrap: pcnt and hcnt never exceed PRESCALE-1 and PERIOD-1.
  - If PERIOD is rewritten smaller while hcnt is larger, the counters reset per the PERIOD-write rule, so no overflow path exists.

## Test plan
Run with WIDTH = 4 and PRESCALE = 4.

- **Reset:** hold reset_n low for 3 cycles with writes active → `out_port` = 0 and `readdata` = 0. After release, reading PERIOD returns 0 and reading STATUS returns 0.
- **Data/set/clear:**
  - Write DATA = 0x5 → `out_port` = 0x5 two edges after the write.
  - OUTSET 0x2 → 0x7.
  - OUTCLEAR 0x4 → 0x3.
  - Reading DATA returns 0x3.
  - Reading OUTSET returns 0.
- **Blink:** DATA = 0xF, BLINK_MASK = 0x3, PERIOD = 2 at edge k → `out_port` = 0xF until edge k+9, then 0xC during edges k+9..k+16, then 0xF at k+17; repeats with a 16-cycle period.
- **Period 0 / rewrite:**
  - Mid-blink with `out_port` = 0xC, write PERIOD = 0 → `out_port` = 0xF next cycle and stays there.
  - Write PERIOD = 1 coincident with a tick → the first toggle comes exactly 4 cycles after the write.
- **Mask change:** while blinking, clear BLINK_MASK → `out_port` = DATA within 2 cycles. Phase continues counting, which is checked by re-enabling the mask and confirming toggle alignment is unchanged.
- **Reset mid-blink:** assert reset_n low while phase = 0 → the next edge gives `out_port` = 0. After release, a PERIOD = 0 readback and DATA = 0 are confirmed.
